// File: rtl/rv32i_ex_csr_unit_pkg.sv
// Shared CSR definitions for the EX-stage CSR unit: addresses, funct3
// operation codes, mstatus bit positions, write masks and the CSR
// read-modify-write helper used by both the commit path and the ID bypass.
package rv32i_ex_csr_unit_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;

  // Counter addresses (only mapped when the counters are built in)
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  // addr[11:10] == 2'b11 marks the read-only CSR space
  localparam logic [1:0] CSR_RO_SPACE = 2'b11;

  // funct3[1:0] operation codes; funct3[2] selects the immediate source
  localparam logic [1:0] CSR_OP_NONE = 2'b00;
  localparam logic [1:0] CSR_OP_RW   = 2'b01;
  localparam logic [1:0] CSR_OP_RS   = 2'b10;
  localparam logic [1:0] CSR_OP_RC   = 2'b11;

  // mstatus bit positions and write masks
  localparam int          MSTATUS_MIE_BIT  = 3;
  localparam int          MSTATUS_MPIE_BIT = 7;
  localparam logic [31:0] MSTATUS_WMASK    = 32'h0000_0088;
  localparam logic [31:0] ALIGN4_MASK      = 32'hFFFF_FFFC;

  // Read-modify-write result of a CSR instruction; a no-op returns old
  function automatic logic [31:0] csr_apply_op(input logic [1:0]  op,
                                               input logic [31:0] old_val,
                                               input logic [31:0] src);
    logic [31:0] res;
    case (op)
      CSR_OP_RW: res = src;
      CSR_OP_RS: res = old_val | src;
      CSR_OP_RC: res = old_val & ~src;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rv32i_csr_counter64.sv
// 64-bit CSR counter with independent 32-bit half writes.
// Only built when RV32I_CSR_COUNTERS_EN is defined.
// A write to either half replaces that cycle's increment and holds the
// other half, so no carry is ever produced by a write.
`ifdef RV32I_CSR_COUNTERS_EN
module rv32i_csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] q
);

  logic [63:0] count;

  // Counter state: reset, half write, or increment with natural 64-bit wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 64'd0;
    end else if (wr_lo) begin
      count[31:0] <= wdata;
    end else if (wr_hi) begin
      count[63:32] <= wdata;
    end else if (inc) begin
      count <= count + 64'd1;
    end else begin
      count <= count;
    end
  end

  assign q = count;

endmodule
`endif

// File: rtl/rv32i_ex_csr_unit.sv
// EX-stage CSR unit: machine-mode CSR file, ID read port with EX write
// bypass, CSRRW/RS/RC(I) execution, trap entry, MRET and optional counters.
// Optional feature macro: RV32I_CSR_COUNTERS_EN (mcycle/minstret and their
// read-only user shadows); without it all counter addresses are unmapped.
module rv32i_ex_csr_unit
  import rv32i_ex_csr_unit_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] id_csr_raddr,
  output logic [31:0] id_csr_rdata,
  input  logic        ex_csr_we,
  input  logic [11:0] ex_csr_waddr,
  input  logic [2:0]  ex_alufun3,
  input  logic [31:0] ex_zimm,
  input  logic [31:0] ex_rs1_data,
  input  logic [31:0] ex_csr_rdata,
  output logic [31:0] ex_rd_wdata,
  output logic        ex_csr_illegal,
  input  logic        instr_retire,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic        mret_valid,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_o
);

  // Architectural state
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mtvec;
  logic [31:0] mscratch;
  logic [31:0] mepc;
  logic [31:0] mcause;

  // Write path
  logic [31:0] wr_src;
  logic [31:0] wr_new;
  logic [31:0] wr_value;
  logic        waddr_mapped;
  logic        waddr_ro;
  logic        wr_is_mstatus;
  logic        csr_wr;
  logic        wr_commit;
  logic [31:0] rd_value;

`ifdef RV32I_CSR_COUNTERS_EN
  logic [63:0] mcycle;
  logic [63:0] minstret;
  logic        mcycle_wr_lo;
  logic        mcycle_wr_hi;
  logic        minstret_wr_lo;
  logic        minstret_wr_hi;
`else
  logic        unused_retire;
  assign unused_retire = instr_retire;
`endif

  assign wr_src = ex_alufun3[2] ? ex_zimm : ex_rs1_data;
  assign wr_new = csr_apply_op(ex_alufun3[1:0], ex_csr_rdata, wr_src);

  // Address decode of the EX access and the value the target would read back
  always_comb begin
    waddr_mapped = 1'b0;
    wr_value     = wr_new;
    case (ex_csr_waddr)
      CSR_MSTATUS: begin
        waddr_mapped = 1'b1;
        wr_value     = wr_new & MSTATUS_WMASK;
      end
      CSR_MISA: begin
        waddr_mapped = 1'b1;
        wr_value     = MISA_VALUE;
      end
      CSR_MTVEC, CSR_MSCRATCH, CSR_MCAUSE: begin
        waddr_mapped = 1'b1;
        wr_value     = wr_new;
      end
      CSR_MEPC: begin
        waddr_mapped = 1'b1;
        wr_value     = wr_new & ALIGN4_MASK;
      end
`ifdef RV32I_CSR_COUNTERS_EN
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
      CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH: begin
        waddr_mapped = 1'b1;
        wr_value     = wr_new;
      end
`endif
      default: begin
        waddr_mapped = 1'b0;
        wr_value     = 32'h0000_0000;
      end
    endcase
  end

  assign waddr_ro       = (ex_csr_waddr[11:10] == CSR_RO_SPACE);
  assign ex_csr_illegal = ex_csr_we & (~waddr_mapped | waddr_ro);
  assign ex_rd_wdata    = ex_csr_rdata;
  assign wr_is_mstatus  = (ex_csr_waddr == CSR_MSTATUS);

  // A trap drops the write entirely; MRET only takes mstatus away from it
  assign csr_wr    = ex_csr_we & ~ex_csr_illegal &
                     (ex_alufun3[1:0] != CSR_OP_NONE) & ~trap_valid;
  assign wr_commit = csr_wr & ~(wr_is_mstatus & mret_valid);

  // ID-side read mux over the current register contents
  always_comb begin
    rd_value = 32'h0000_0000;
    case (id_csr_raddr)
      CSR_MSTATUS:  rd_value = {24'h00_0000, mstatus_mpie, 3'b000, mstatus_mie, 3'b000};
      CSR_MISA:     rd_value = MISA_VALUE;
      CSR_MTVEC:    rd_value = mtvec;
      CSR_MSCRATCH: rd_value = mscratch;
      CSR_MEPC:     rd_value = mepc;
      CSR_MCAUSE:   rd_value = mcause;
`ifdef RV32I_CSR_COUNTERS_EN
      CSR_MCYCLE,   CSR_CYCLE:    rd_value = mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:   rd_value = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:  rd_value = minstret[31:0];
      CSR_MINSTRETH,CSR_INSTRETH: rd_value = minstret[63:32];
`endif
      default:      rd_value = 32'h0000_0000;
    endcase
  end

  // ID read data, forwarding the value an EX write is about to commit
  always_comb begin
    if (wr_commit && (id_csr_raddr == ex_csr_waddr)) begin
      id_csr_rdata = wr_value;
    end else begin
      id_csr_rdata = rd_value;
    end
  end

  // mstatus MIE/MPIE: trap, then MRET, then CSR write
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (trap_valid) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret_valid) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (wr_commit && wr_is_mstatus) begin
      mstatus_mie  <= wr_value[MSTATUS_MIE_BIT];
      mstatus_mpie <= wr_value[MSTATUS_MPIE_BIT];
    end else begin
      mstatus_mie  <= mstatus_mie;
      mstatus_mpie <= mstatus_mpie;
    end
  end

  // mtvec and mscratch: plain CSR-written registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mtvec    <= MTVEC_RESET & ALIGN4_MASK;
      mscratch <= 32'h0000_0000;
    end else begin
      if (wr_commit && (ex_csr_waddr == CSR_MTVEC)) begin
        mtvec <= wr_value;
      end else begin
        mtvec <= mtvec;
      end
      if (wr_commit && (ex_csr_waddr == CSR_MSCRATCH)) begin
        mscratch <= wr_value;
      end else begin
        mscratch <= mscratch;
      end
    end
  end

  // mepc and mcause: trap entry has priority over CSR writes
  always_ff @(posedge clk) begin
    if (rst) begin
      mepc   <= 32'h0000_0000;
      mcause <= 32'h0000_0000;
    end else if (trap_valid) begin
      mepc   <= trap_pc & ALIGN4_MASK;
      mcause <= trap_cause;
    end else begin
      if (wr_commit && (ex_csr_waddr == CSR_MEPC)) begin
        mepc <= wr_value;
      end else begin
        mepc <= mepc;
      end
      if (wr_commit && (ex_csr_waddr == CSR_MCAUSE)) begin
        mcause <= wr_value;
      end else begin
        mcause <= mcause;
      end
    end
  end

`ifdef RV32I_CSR_COUNTERS_EN
  assign mcycle_wr_lo   = wr_commit & (ex_csr_waddr == CSR_MCYCLE);
  assign mcycle_wr_hi   = wr_commit & (ex_csr_waddr == CSR_MCYCLEH);
  assign minstret_wr_lo = wr_commit & (ex_csr_waddr == CSR_MINSTRET);
  assign minstret_wr_hi = wr_commit & (ex_csr_waddr == CSR_MINSTRETH);

  rv32i_csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (mcycle_wr_lo),
    .wr_hi (mcycle_wr_hi),
    .wdata (wr_value),
    .q     (mcycle)
  );

  rv32i_csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instr_retire),
    .wr_lo (minstret_wr_lo),
    .wr_hi (minstret_wr_hi),
    .wdata (wr_value),
    .q     (minstret)
  );
`endif

  assign mtvec_o = mtvec;
  assign mepc_o  = mepc;
  assign mie_o   = mstatus_mie;

endmodule

// File: tb/tb_rv32i_ex_csr_unit.sv
// Self-checking bench for rv32i_ex_csr_unit: directed scenarios followed by
// randomized traffic, all checked against a behavioural CSR model.
module tb_rv32i_ex_csr_unit;

  localparam logic [31:0] TB_MTVEC = 32'h0000_1003;
  localparam logic [31:0] TB_MISA  = 32'h4000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] id_csr_raddr;
  logic [31:0] id_csr_rdata;
  logic        ex_csr_we;
  logic [11:0] ex_csr_waddr;
  logic [2:0]  ex_alufun3;
  logic [31:0] ex_zimm;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_csr_rdata;
  logic [31:0] ex_rd_wdata;
  logic        ex_csr_illegal;
  logic        instr_retire;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic        mret_valid;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        mie_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  logic        m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_mcycle, m_minstret;

  logic [11:0] addr_pool [13] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                                  12'hB00, 12'hB80, 12'hB02, 12'hC00, 12'hC82, 12'h7C0, 12'h123};

  rv32i_ex_csr_unit #(.MTVEC_RESET(TB_MTVEC), .MISA_VALUE(TB_MISA)) dut (
    .clk(clk), .rst(rst),
    .id_csr_raddr(id_csr_raddr), .id_csr_rdata(id_csr_rdata),
    .ex_csr_we(ex_csr_we), .ex_csr_waddr(ex_csr_waddr), .ex_alufun3(ex_alufun3),
    .ex_zimm(ex_zimm), .ex_rs1_data(ex_rs1_data), .ex_csr_rdata(ex_csr_rdata),
    .ex_rd_wdata(ex_rd_wdata), .ex_csr_illegal(ex_csr_illegal),
    .instr_retire(instr_retire), .trap_valid(trap_valid), .trap_pc(trap_pc),
    .trap_cause(trap_cause), .mret_valid(mret_valid),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_o(mie_o)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_mapped(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342: return 1'b1;
`ifdef RV32I_CSR_COUNTERS_EN
      12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return {24'd0, m_mpie, 3'd0, m_mie, 3'd0};
      12'h301: return TB_MISA;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
`ifdef RV32I_CSR_COUNTERS_EN
      12'hB00, 12'hC00: return m_mcycle[31:0];
      12'hB80, 12'hC80: return m_mcycle[63:32];
      12'hB02, 12'hC02: return m_minstret[31:0];
      12'hB82, 12'hC82: return m_minstret[63:32];
`endif
      default: return 32'd0;
    endcase
  endfunction

  // What a CSR reads back after being written with v
  function automatic logic [31:0] m_shape(input logic [11:0] a, input logic [31:0] v);
    case (a)
      12'h300: return v & 32'h0000_0088;
      12'h301: return TB_MISA;
      12'h341: return v & 32'hFFFF_FFFC;
      default: return v;
    endcase
  endfunction

  task automatic model_reset();
    m_mie = 1'b0; m_mpie = 1'b0;
    m_mtvec = TB_MTVEC & 32'hFFFF_FFFC;
    m_mscratch = 32'd0; m_mepc = 32'd0; m_mcause = 32'd0;
    m_mcycle = 64'd0; m_minstret = 64'd0;
  endtask

  task automatic set_idle();
    rst = 1'b0; id_csr_raddr = 12'h000; ex_csr_we = 1'b0; ex_csr_waddr = 12'h000;
    ex_alufun3 = 3'b000; ex_zimm = 32'd0; ex_rs1_data = 32'd0; ex_csr_rdata = 32'd0;
    instr_retire = 1'b0; trap_valid = 1'b0; trap_pc = 32'd0; trap_cause = 32'd0;
    mret_valid = 1'b0;
  endtask

  task automatic csr_access(input logic we, input logic [11:0] a, input logic [2:0] f3,
                            input logic [31:0] rs1, input logic [4:0] z);
    ex_csr_we = we; ex_csr_waddr = a; ex_alufun3 = f3;
    ex_rs1_data = rs1; ex_zimm = {27'd0, z}; ex_csr_rdata = m_read(a);
  endtask

  // Check every output against the model, then advance one clock edge
  task automatic run_cycle();
    logic [31:0] src, newv, exp_id;
    logic        exp_ill, commit, wr_cyc, wr_ins;
    src = ex_alufun3[2] ? ex_zimm : ex_rs1_data;
    case (ex_alufun3[1:0])
      2'b01:   newv = src;
      2'b10:   newv = ex_csr_rdata | src;
      2'b11:   newv = ex_csr_rdata & ~src;
      default: newv = ex_csr_rdata;
    endcase
    exp_ill = ex_csr_we && (!m_mapped(ex_csr_waddr) || ex_csr_waddr[11:10] == 2'b11);
    commit  = ex_csr_we && !exp_ill && ex_alufun3[1:0] != 2'b00 && !trap_valid &&
              !(ex_csr_waddr == 12'h300 && mret_valid);
    exp_id  = (commit && id_csr_raddr == ex_csr_waddr) ? m_shape(ex_csr_waddr, newv)
                                                       : m_read(id_csr_raddr);
    #1;
    check_eq("rd_wdata", ex_rd_wdata, ex_csr_rdata);
    check_eq("illegal", {31'd0, ex_csr_illegal}, {31'd0, exp_ill});
    check_eq("id_rdata", id_csr_rdata, exp_id);
    check_eq("mtvec", mtvec_o, m_mtvec);
    check_eq("mepc", mepc_o, m_mepc);
    check_eq("mie", {31'd0, mie_o}, {31'd0, m_mie});
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      wr_cyc = commit && (ex_csr_waddr == 12'hB00 || ex_csr_waddr == 12'hB80);
      wr_ins = commit && (ex_csr_waddr == 12'hB02 || ex_csr_waddr == 12'hB82);
      if (!wr_cyc) m_mcycle = m_mcycle + 64'd1;
      if (!wr_ins && instr_retire) m_minstret = m_minstret + 64'd1;
      if (commit) begin
        case (ex_csr_waddr)
          12'h300: begin m_mie = newv[3]; m_mpie = newv[7]; end
          12'h305: m_mtvec = newv;
          12'h340: m_mscratch = newv;
          12'h341: m_mepc = newv & 32'hFFFF_FFFC;
          12'h342: m_mcause = newv;
          12'hB00: m_mcycle[31:0] = newv;
          12'hB80: m_mcycle[63:32] = newv;
          12'hB02: m_minstret[31:0] = newv;
          12'hB82: m_minstret[63:32] = newv;
          default: ;
        endcase
      end
      if (trap_valid) begin
        m_mepc = trap_pc & 32'hFFFF_FFFC; m_mcause = trap_cause;
        m_mpie = m_mie; m_mie = 1'b0;
      end else if (mret_valid) begin
        m_mie = m_mpie; m_mpie = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;

    // 1: reset values
    id_csr_raddr = 12'h305; #1 check_eq("mtvec_reset", id_csr_rdata, 32'h0000_1000);
    id_csr_raddr = 12'h301; #1 check_eq("misa", id_csr_rdata, 32'h4000_0100);
    check_eq("mie_reset", {31'd0, mie_o}, 32'd0);
    run_cycle();

    // 2: CSRRW / CSRRCI on mscratch
    set_idle(); csr_access(1'b1, 12'h340, 3'b001, 32'hDEAD_BEEF, 5'd0);
    #1 check_eq("csrrw_old", ex_rd_wdata, 32'd0);
    run_cycle();
    set_idle(); id_csr_raddr = 12'h340;
    #1 check_eq("mscratch_rw", id_csr_rdata, 32'hDEAD_BEEF);
    csr_access(1'b1, 12'h340, 3'b111, 32'd0, 5'h0F);
    run_cycle();
    set_idle(); id_csr_raddr = 12'h340;
    #1 check_eq("mscratch_rci", id_csr_rdata, 32'hDEAD_BEE0);
    run_cycle();

    // 3: bypass of CSRRSI mstatus to a same-cycle ID read
    set_idle(); id_csr_raddr = 12'h300; csr_access(1'b1, 12'h300, 3'b110, 32'd0, 5'h08);
    #1 check_eq("bypass_mstatus", id_csr_rdata, 32'h0000_0008);
    run_cycle();
    set_idle(); #1 check_eq("mie_set", {31'd0, mie_o}, 32'd1);
    run_cycle();

    // 4: trap beats a concurrent mepc write, then MRET
    set_idle(); trap_valid = 1'b1; trap_pc = 32'h0000_0103; trap_cause = 32'd11;
    csr_access(1'b1, 12'h341, 3'b001, 32'h5555_5555, 5'd0);
    run_cycle();
    set_idle(); id_csr_raddr = 12'h342;
    #1 check_eq("trap_mepc", mepc_o, 32'h0000_0100);
    check_eq("trap_mcause", id_csr_rdata, 32'd11);
    check_eq("trap_mie", {31'd0, mie_o}, 32'd0);
    id_csr_raddr = 12'h300; #1 check_eq("trap_mpie", id_csr_rdata, 32'h0000_0080);
    run_cycle();
    set_idle(); mret_valid = 1'b1; run_cycle();
    set_idle(); #1 check_eq("mret_mie", {31'd0, mie_o}, 32'd1);
    run_cycle();

    // 5: illegal accesses
    set_idle(); csr_access(1'b1, 12'hC00, 3'b001, 32'h1234_5678, 5'd0);
    #1 check_eq("ill_c00", {31'd0, ex_csr_illegal}, 32'd1);
    run_cycle();
    set_idle(); csr_access(1'b1, 12'h7C0, 3'b010, 32'hFFFF_FFFF, 5'd0);
    #1 check_eq("ill_7c0", {31'd0, ex_csr_illegal}, 32'd1);
    run_cycle();
    set_idle(); csr_access(1'b0, 12'hC00, 3'b010, 32'd0, 5'd0);
    #1 check_eq("ro_read_ok", {31'd0, ex_csr_illegal}, 32'd0);
    run_cycle();

    // 6: counters
`ifdef RV32I_CSR_COUNTERS_EN
    set_idle(); csr_access(1'b1, 12'hB00, 3'b001, 32'hFFFF_FFFF, 5'd0); run_cycle();
    set_idle(); csr_access(1'b1, 12'hB80, 3'b001, 32'hFFFF_FFFF, 5'd0); run_cycle();
    set_idle(); run_cycle();
    set_idle(); id_csr_raddr = 12'hB80; #1 check_eq("mcycleh_wrap", id_csr_rdata, 32'd0);
    id_csr_raddr = 12'hB00; #1 check_eq("mcycle_wrap", id_csr_rdata, 32'd0);
    run_cycle();
    #1 check_eq("mcycle_inc", id_csr_rdata, 32'd1);
    repeat (5) run_cycle();
    rst = 1'b1; run_cycle();
    set_idle(); id_csr_raddr = 12'hB00; #1 check_eq("mcycle_rst", id_csr_rdata, 32'd0);
    run_cycle();
`else
    set_idle(); id_csr_raddr = 12'hB00; #1 check_eq("b00_unmapped", id_csr_rdata, 32'd0);
    csr_access(1'b1, 12'hB00, 3'b001, 32'h1, 5'd0);
    #1 check_eq("b00_illegal", {31'd0, ex_csr_illegal}, 32'd1);
    run_cycle();
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_idle();
      rst = ($urandom_range(0, 63) == 0);
      csr_access($urandom_range(0, 3) != 0, addr_pool[$urandom_range(0, 12)],
                 3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) ex_csr_rdata = $urandom;
      id_csr_raddr = ($urandom_range(0, 1) == 0) ? ex_csr_waddr : addr_pool[$urandom_range(0, 12)];
      instr_retire = $urandom_range(0, 1) == 1;
      trap_valid   = ($urandom_range(0, 11) == 0);
      trap_pc      = $urandom;
      trap_cause   = $urandom;
      mret_valid   = ($urandom_range(0, 7) == 0);
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
